// File: rtl/sync_debounce.sv
// Input conditioner: per-channel multi-stage synchronizer followed by an
// optional debounce counter, producing clean levels plus rise/fall pulses.
module sync_debounce #(
  parameter int WIDTH       = 10,
  parameter int STAGES      = 2,
  parameter int DB_CYCLES   = 4,
  parameter bit DEBOUNCE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] stable_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // With debounce disabled the channel accepts a new level after one cycle.
  localparam int EFF_CYCLES = DEBOUNCE_EN ? DB_CYCLES : 1;
  localparam int CW         = $clog2(EFF_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(EFF_CYCLES - 1);

  logic [WIDTH-1:0] sync_reg [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < STAGES; s++) begin
        sync_reg[s] <= '0;
      end
    end else begin
      sync_reg[0] <= async_in;
      for (int s = 1; s < STAGES; s++) begin
        sync_reg[s] <= sync_reg[s-1];
      end
    end
  end

  assign sync_out = sync_reg[STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic [CW-1:0] cnt_reg, cnt_next;
      logic          stable_reg, stable_next;
      logic          rise_reg, rise_next;
      logic          fall_reg, fall_next;

      // A mismatch must persist for EFF_CYCLES evaluations before acceptance;
      // any return to equality discards the partial count.
      always_comb begin
        cnt_next    = cnt_reg;
        stable_next = stable_reg;
        rise_next   = 1'b0;
        fall_next   = 1'b0;
        if (sync_out[gi] == stable_reg) begin
          cnt_next = '0;
        end else if (cnt_reg == LAST) begin
          cnt_next    = '0;
          stable_next = sync_out[gi];
          rise_next   = sync_out[gi];
          fall_next   = ~sync_out[gi];
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg    <= '0;
          stable_reg <= 1'b0;
          rise_reg   <= 1'b0;
          fall_reg   <= 1'b0;
        end else begin
          cnt_reg    <= cnt_next;
          stable_reg <= stable_next;
          rise_reg   <= rise_next;
          fall_reg   <= fall_next;
        end
      end

      assign stable_out[gi] = stable_reg;
      assign rise[gi]       = rise_reg;
      assign fall[gi]       = fall_reg;
    end
  endgenerate

endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce: default configuration plus a
// three-stage, debounce-disabled instance.
module tb_sync_debounce;

  logic       clk;
  logic       reset_n;
  logic [9:0] async_in;
  logic [9:0] sync_out, stable_out, rise, fall;
  logic [9:0] async_in2;
  logic [9:0] sync_out2, stable_out2, rise2, fall2;

  int errors = 0;
  int checks = 0;

  sync_debounce #(.WIDTH(10), .STAGES(2), .DB_CYCLES(4), .DEBOUNCE_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .async_in(async_in),
    .sync_out(sync_out), .stable_out(stable_out), .rise(rise), .fall(fall)
  );

  sync_debounce #(.WIDTH(10), .STAGES(3), .DB_CYCLES(4), .DEBOUNCE_EN(1'b0)) dut2 (
    .clk(clk), .reset_n(reset_n), .async_in(async_in2),
    .sync_out(sync_out2), .stable_out(stable_out2), .rise(rise2), .fall(fall2)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  int rise_cnt, fall_cnt, stab_cnt, sync_cnt, rise_at, both_cnt;

  initial begin
    reset_n   = 1'b0;
    async_in  = 10'h3FF;
    async_in2 = 10'h000;

    // Reset held with inputs high
    tick(5);
    check("rst_sync",   sync_out,   10'h000);
    check("rst_stable", stable_out, 10'h000);
    check("rst_rise",   rise,       10'h000);
    check("rst_fall",   fall,       10'h000);

    // Release: following edge is E0
    reset_n = 1'b1;
    tick(1);                                   // E0
    tick(1);                                   // E1
    check("rel_sync_E1", sync_out, 10'h3FF);
    tick(3);                                   // E4
    check("rel_stable_E4", stable_out, 10'h000);
    tick(1);                                   // E5
    check("rel_stable_E5", stable_out, 10'h3FF);
    check("rel_rise_E5",   rise,       10'h3FF);
    tick(1);                                   // E6
    check("rel_rise_E6", rise, 10'h000);

    // Drop all to zero
    async_in = 10'h000;
    tick(6);                                   // E5
    check("drop_fall_E5",   fall,       10'h3FF);
    check("drop_stable_E5", stable_out, 10'h000);
    tick(3);

    // Clean step 000 -> 0A5
    async_in = 10'h0A5;
    tick(2);                                   // E1
    check("step_sync_E1", sync_out, 10'h0A5);
    tick(3);                                   // E4
    check("step_rise_E4", rise, 10'h000);
    tick(1);                                   // E5
    check("step_rise_E5",   rise,       10'h0A5);
    check("step_stable_E5", stable_out, 10'h0A5);
    tick(1);                                   // E6
    check("step_rise_E6", rise, 10'h000);
    tick(2);

    // 0A5 -> 05A
    async_in = 10'h05A;
    tick(6);                                   // E5
    check("swap_fall_E5",   fall,       10'h0A5);
    check("swap_rise_E5",   rise,       10'h05A);
    check("swap_stable_E5", stable_out, 10'h05A);
    tick(1);
    check("swap_fall_E6", fall, 10'h000);

    async_in = 10'h000;
    tick(10);
    check("clear_stable", stable_out, 10'h000);

    // Glitch: bit 0 high for 3 cycles is rejected
    async_in = 10'h001;
    sync_cnt = 0; stab_cnt = 0; rise_cnt = 0; fall_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      if (sync_out[0]) sync_cnt++;
      if (stable_out[0]) stab_cnt++;
      if (rise[0]) rise_cnt++;
      if (fall[0]) fall_cnt++;
    end
    async_in = 10'h000;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (sync_out[0]) sync_cnt++;
      if (stable_out[0]) stab_cnt++;
      if (rise[0]) rise_cnt++;
      if (fall[0]) fall_cnt++;
    end
    check("glitch3_sync_cycles", sync_cnt, 3);
    check("glitch3_stable",      stab_cnt, 0);
    check("glitch3_rise",        rise_cnt, 0);
    check("glitch3_fall",        fall_cnt, 0);

    // Bit 0 high for exactly 4 cycles is accepted
    async_in = 10'h001;
    rise_cnt = 0; rise_at = -1;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      if (rise[0]) begin rise_cnt++; rise_at = k; end
    end
    async_in = 10'h000;
    for (int k = 4; k < 14; k++) begin
      tick(1);
      if (rise[0]) begin rise_cnt++; rise_at = k; end
    end
    check("pulse4_rise_count", rise_cnt, 1);
    check("pulse4_rise_edge",  rise_at,  5);
    tick(4);
    check("pulse4_back_low", stable_out, 10'h000);

    // Bounce on bit 3, then steady high
    for (int k = 0; k < 10; k++) begin
      async_in = (k % 2 == 0) ? 10'h008 : 10'h000;
      tick(1);
      if (rise[3]) rise_cnt++;
    end
    rise_cnt = 0; rise_at = -1; both_cnt = 0;
    async_in = 10'h008;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (rise[3]) begin rise_cnt++; rise_at = k; end
      if ((rise & fall) != 10'h000) both_cnt++;
    end
    check("bounce_rise_count", rise_cnt, 1);
    check("bounce_rise_edge",  rise_at,  5);
    check("bounce_no_overlap", both_cnt, 0);

    // Reset mid-count on bit 5
    async_in = 10'h020;
    rise_cnt = 0;
    for (int k = 0; k < 4; k++) begin         // E0..E3
      tick(1);
      if (rise[5]) rise_cnt++;
    end
    reset_n = 1'b0;
    #1;
    check("midrst_sync",   sync_out,   10'h000);
    check("midrst_stable", stable_out, 10'h000);
    check("midrst_rise",   rise_cnt,   0);
    tick(1);
    reset_n = 1'b1;
    tick(1);                                   // E0
    tick(1);                                   // E1
    check("midrst_sync_E1", sync_out, 10'h020);
    tick(3);                                   // E4
    check("midrst_rise_E4", rise, 10'h000);
    tick(1);                                   // E5
    check("midrst_rise_E5",   rise,       10'h020);
    check("midrst_stable_E5", stable_out, 10'h020);

    // Three-stage instance, debounce disabled
    async_in2 = 10'h003;
    tick(1);                                   // E0
    tick(2);                                   // E2
    check("nodb_sync_E2",   sync_out2,   10'h003);
    check("nodb_stable_E2", stable_out2, 10'h000);
    tick(1);                                   // E3
    check("nodb_stable_E3", stable_out2, 10'h003);
    check("nodb_rise_E3",   rise2,       10'h003);
    tick(1);                                   // E4
    check("nodb_rise_E4", rise2, 10'h000);
    tick(2);

    // One-cycle glitch on bit 2 propagates
    async_in2 = 10'h007;
    tick(1);                                   // E0
    async_in2 = 10'h003;
    tick(2);                                   // E2
    check("nodb_gl_sync_E2", sync_out2, 10'h007);
    tick(1);                                   // E3
    check("nodb_gl_stable_E3", stable_out2, 10'h007);
    check("nodb_gl_rise_E3",   rise2,       10'h004);
    tick(1);                                   // E4
    check("nodb_gl_stable_E4", stable_out2, 10'h003);
    check("nodb_gl_fall_E4",   fall2,       10'h004);
    check("nodb_gl_rise_E4",   rise2,       10'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
